// File: rtl/da_lut_loader.sv
// Distributed-arithmetic LUT generator: holds 64 coefficients and streams
// the 2048-entry partial-sum table (8 groups of 256) to fir_filter.
module da_lut_loader #(
    parameter int NTAPS = 64,
    parameter int CW    = 16,
    parameter int LW    = 20
) (
    input  logic          clk_slow,
    input  logic          reset,
    input  logic          coef_we,
    input  logic [5:0]    coef_addr,
    input  logic [CW-1:0] coef_data,
    input  logic          start,
    output logic [LW-1:0] CIN,
    output logic [10:0]   CADDR,
    output logic          CLOAD,
    output logic          busy,
    output logic          done,
    output logic          coef_wr_err
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t        state_q, state_d;
    logic [10:0]   caddr_q, caddr_d;
    logic          err_q, err_d;
    logic [CW-1:0] coef_q [NTAPS];
    logic [CW-1:0] coef_d [NTAPS];
    logic [LW-1:0] acc;
    logic [CW-1:0] term;

    // State register
    always_ff @(posedge clk_slow) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (caddr_q == 11'd2047) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy  = (state_q == LOAD);
        CLOAD = (state_q == LOAD);
        done  = (state_q == DONE);
    end

    always_comb begin
        caddr_d = 11'd0;
        if (state_q == LOAD && caddr_q != 11'd2047) begin
            caddr_d = caddr_q + 11'd1;
        end
        err_d  = coef_we && (state_q != IDLE);
        coef_d = coef_q;
        if (coef_we && state_q == IDLE) begin
            coef_d[coef_addr] = coef_data;
        end
    end

    always_ff @(posedge clk_slow) begin
        if (reset) begin
            caddr_q <= 11'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            caddr_q <= caddr_d;
            err_q   <= err_d;
            coef_q  <= coef_d;
        end
    end

    // Entry for the current address, summed from the live register file
    always_comb begin
        acc  = '0;
        term = '0;
        for (int b = 0; b < 8; b++) begin
            term = coef_q[{caddr_q[10:8], b[2:0]}];
            if (caddr_q[b]) begin
                acc = acc + {{(LW-CW){term[CW-1]}}, term};
            end
        end
    end

    assign CIN         = (state_q == LOAD) ? acc : '0;
    assign CADDR       = caddr_q;
    assign coef_wr_err = err_q;

endmodule

// File: tb/tb_da_lut_loader.sv
// Directed self-checking bench for da_lut_loader.
module tb_da_lut_loader;

    logic        clk_slow = 1'b0;
    logic        reset = 1'b1;
    logic        coef_we = 1'b0;
    logic [5:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        start = 1'b0;
    logic [19:0] CIN;
    logic [10:0] CADDR;
    logic        CLOAD;
    logic        busy;
    logic        done;
    logic        coef_wr_err;

    int errors = 0;
    int checks = 0;

    logic [19:0] got [2048];
    logic [19:0] ref_tbl [2048];

    da_lut_loader dut (
        .clk_slow    (clk_slow),
        .reset       (reset),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .start       (start),
        .CIN         (CIN),
        .CADDR       (CADDR),
        .CLOAD       (CLOAD),
        .busy        (busy),
        .done        (done),
        .coef_wr_err (coef_wr_err)
    );

    always #5 clk_slow = ~clk_slow;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        coef_we   = 1'b1;
        coef_addr = a[5:0];
        coef_data = d;
        @(negedge clk_slow);
        coef_we   = 1'b0;
    endtask

    task automatic fill(input logic [15:0] d);
        for (int a = 0; a < 64; a++) wr(a, d);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cload"}, {31'd0, CLOAD}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_caddr"}, {21'd0, CADDR}, 32'd0);
        check({tag, "_cin"}, {12'd0, CIN}, 32'd0);
    endtask

    // Start a load, capture the table; inj>=0 issues start+coef_we mid-load
    task automatic stream(input int inj);
        start = 1'b1;
        @(negedge clk_slow);
        start   = 1'b0;
        coef_we = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            check("cload", {31'd0, CLOAD}, 32'd1);
            check("caddr", {21'd0, CADDR}, i);
            got[i] = CIN;
            if (i == inj + 1) check("wr_err_pulse", {31'd0, coef_wr_err}, 32'd1);
            if (i == inj + 2) check("wr_err_low", {31'd0, coef_wr_err}, 32'd0);
            if (i == inj) begin
                start     = 1'b1;
                coef_we   = 1'b1;
                coef_addr = 6'd0;
                coef_data = 16'h0001;
            end else begin
                start   = 1'b0;
                coef_we = 1'b0;
            end
            @(negedge clk_slow);
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check_idle("end");
        @(negedge clk_slow);
        check("done_low", {31'd0, done}, 32'd0);
        check("no_restart", {31'd0, busy}, 32'd0);
    endtask

    task automatic cmp_ref(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 2048; i++) if (got[i] !== ref_tbl[i]) bad++;
        check(tag, bad, 32'd0);
    endtask

    initial begin
        int bad;
        int dones;
        // Reset state
        @(negedge clk_slow);
        @(negedge clk_slow);
        check_idle("rst");
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, coef_wr_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk_slow);

        // All ones: entry is popcount of the low address byte
        fill(16'd1);
        stream(-10);
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            if (got[i] !== 20'($countones(i[7:0]))) bad++;
        end
        check("popcount_tbl", bad, 32'd0);
        check("ones_a0", {12'd0, got[0]}, 32'd0);
        check("ones_a255", {12'd0, got[255]}, 32'd8);
        check("ones_a2047", {12'd0, got[2047]}, 32'd8);

        // Sparse coefficients in group 1
        fill(16'd0);
        wr(8, 16'd5);
        wr(15, 16'd7);
        stream(-10);
        check("sp_a385", {12'd0, got[385]}, 32'd12);
        check("sp_a257", {12'd0, got[257]}, 32'd5);
        check("sp_a1", {12'd0, got[1]}, 32'd0);
        check("sp_a1921", {12'd0, got[1921]}, 32'd0);

        // Most negative coefficients
        fill(16'h8000);
        stream(-10);
        check("neg_a255", {12'd0, got[255]}, 32'h000C0000);
        check("neg_a1", {12'd0, got[1]}, 32'h000F8000);
        for (int i = 0; i < 2048; i++) ref_tbl[i] = got[i];

        // Start and write during LOAD are ignored
        stream(500);
        cmp_ref("inj_same_tbl");
        stream(-10);
        cmp_ref("repeat_tbl");

        // Write and start in the same IDLE cycle
        coef_we   = 1'b1;
        coef_addr = 6'd0;
        coef_data = 16'd9;
        stream(-10);
        check("ws_a1", {12'd0, got[1]}, 32'd9);
        check("ws_a3", {12'd0, got[3]}, 32'h000F8009);

        // Reset on the 1000th LOAD cycle
        start = 1'b1;
        @(negedge clk_slow);
        start = 1'b0;
        for (int i = 0; i < 999; i++) @(negedge clk_slow);
        check("pre_rst_caddr", {21'd0, CADDR}, 32'd999);
        reset     = 1'b1;
        start     = 1'b1;
        coef_we   = 1'b1;
        coef_addr = 6'd0;
        coef_data = 16'd3;
        @(negedge clk_slow);
        start   = 1'b0;
        coef_we = 1'b0;
        check_idle("midrst");
        check("midrst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 1200; i++) begin
            if (done === 1'b1 || CLOAD === 1'b1) dones++;
            @(negedge clk_slow);
        end
        check("no_done_after_rst", dones, 32'd0);
        stream(-10);
        bad = 0;
        for (int i = 0; i < 2048; i++) if (got[i] !== 20'd0) bad++;
        check("zero_tbl", bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/da_lut_loader.md
DA_LUT_LOADER -- requirements
Module: da_lut_loader

Interface
REQ-001 SHALL have parameter NTAPS, default 64, meaning number of filter coefficients; fixed value, 8 groups of 8.
REQ-002 SHALL have parameter CW, default 16, meaning coefficient width (signed).
REQ-003 SHALL have parameter LW, default 20, meaning LUT entry width (signed).
REQ-004 clk_slow  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 coef_we  in  1  coefficient write strobe.
REQ-007 coef_addr  in  6  coefficient index 0..63.
REQ-008 coef_data  in  16  signed coefficient value.
REQ-009 start  in  1  single-cycle request to generate and stream the table.
REQ-010 CIN  out  20  signed LUT entry to fir_filter.
REQ-011 CADDR  out  11  LUT address to fir_filter.
REQ-012 CLOAD  out  1  load-window enable to fir_filter.
REQ-013 busy  out  1  high while streaming.
REQ-014 done  out  1  one-cycle pulse when the table is complete.
REQ-015 coef_wr_err  out  1  one-cycle pulse when a write is rejected.

Function
REQ-016 SHALL hold a 64 x 16 signed coefficient register file; a write occurs in IDLE when coef_we=1, coef[coef_addr] <= coef_data.
REQ-017 SHALL implement FSM states IDLE, LOAD, DONE; IDLE->LOAD on start=1; LOAD->DONE after address 2047 is presented; DONE->IDLE unconditionally after one cycle.
REQ-018 Entry for address a SHALL be: k=a[10:8], n=a[7:0], CIN = sum over b=0..7 with n[b]=1 of coef[8k+b], each term sign-extended to 20 bits, with no saturation (|sum| <= 2^18 fits).
REQ-019 With start sampled at edge t, CLOAD=1, busy=1, CADDR=0 and CIN=entry(0) SHALL be visible from edge t+1; CADDR SHALL increment by 1 each cycle; CIN SHALL always equal entry(CADDR) in the same cycle.
REQ-020 CADDR=2047 SHALL be presented at edge t+2048; at edge t+2049 CLOAD=0, busy=0, done=1, CADDR=0, CIN=0.
REQ-021 Exactly 2048 consecutive cycles with CLOAD=1 per load, with no gaps or repeated addresses.
REQ-022 start while in LOAD or DONE SHALL be ignored, with no restart and no queuing.
REQ-023 coef_we while in LOAD or DONE SHALL not modify the file, and coef_wr_err SHALL pulse for one cycle.
REQ-024 coef_we and start in the same IDLE cycle: the write SHALL be applied, and the streamed table SHALL use the new value.
REQ-025 Outside LOAD, CIN and CADDR SHALL be 0 and CLOAD SHALL be 0.
REQ-026 Coefficients SHALL persist across loads; a second start SHALL reproduce the identical stream.

Reset
REQ-027 reset=1 at an edge SHALL force state IDLE and set CIN=0, CADDR=0, CLOAD=0, busy=0, done=0, coef_wr_err=0, and all coefficients=0.
REQ-028 reset asserted mid-LOAD SHALL drop CLOAD at that edge, with no done pulse; reset SHALL have priority over start and coef_we.

Verification
REQ-029 All 64 coefs=1, start -> 2048 CLOAD cycles; CIN=popcount(CADDR[7:0]); CADDR 0->0, 255->8, 2047->8; done one cycle after CADDR=2047.
REQ-030 coef[8]=5, coef[15]=7, others 0 -> CADDR 385 (k=1, n=0x81) gives CIN=12, CADDR 257 gives 5, CADDR 1 gives 0, CADDR 1921 gives 0.
REQ-031 All coefs=-32768 -> CADDR 255 gives CIN=20'hC0000 (-262144), CADDR 1 gives 20'hF8000.
REQ-032 reset raised on the 1000th LOAD cycle -> next cycle CLOAD=0, CADDR=0, CIN=0, busy=0, done never pulses; a new start then streams an all-zero table.
REQ-033 start and coef_we issued during LOAD -> streaming continues unbroken, coef_wr_err pulses once, and a subsequent load is unchanged.
REQ-034 coef_we(addr 0, data 9) with start in the same cycle -> CADDR 1 gives CIN=9.
